// File: rtl/apb_pkg.sv
// apb_pkg: shared APB requester types and constants
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
  localparam logic [2:0] PPROT_DEFAULT = 3'b000;
  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = 4;
  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
  } apb_cmd_t;
  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              err;
    logic              timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: ACCESS wait-state counter flagging the timeout threshold
module apb_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = (TIMEOUT != 0) && (32'(cnt_q) == 32'(TIMEOUT - 1));
endmodule

// File: rtl/apb_requester.sv
// apb_requester: APB4 requester with PSEL decode, decode-error and wait-state timeout
module apb_requester
  import apb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int NSLV    = 2,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 256
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [SW-1:0]   cmd_strb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_timeout,
  output logic [AW-1:0]   PADDR,
  output logic [NSLV-1:0] PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [DW-1:0]   PWDATA,
  output logic [SW-1:0]   PSTRB,
  output logic [2:0]      PPROT,
  output logic            PNSE,
  input  logic            PREADY,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PSLVERR
);
  localparam int IDXW = AW - SEL_LSB;
  apb_state_e state_q, state_d;
  logic [NSLV-1:0] psel_q, psel_d, sel_oh;
  logic penable_q, penable_d, pwrite_q, pwrite_d, cmd_ready_q, cmd_ready_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [SW-1:0] pstrb_q, pstrb_d;
  logic [IDXW-1:0] idx;
  logic dec_err, expired;
  assign idx = cmd_addr[AW-1:SEL_LSB];
  assign dec_err = idx >= IDXW'(NSLV);
  always_comb
    for (int i = 0; i < NSLV; i++) sel_oh[i] = idx == IDXW'(i);
  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clr    (state_q == SETUP),
    .en     (state_q == ACCESS && !PREADY),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    psel_d = psel_q;
    penable_d = penable_q;
    paddr_d = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        paddr_d = cmd_addr;
        pwrite_d = cmd_write;
        pwdata_d = cmd_write ? cmd_wdata : '0;
        pstrb_d = cmd_write ? cmd_strb : '0;
        if (dec_err) begin
          rsp_rdata_d = '0;
          rsp_err_d = 1'b1;
          rsp_timeout_d = 1'b0;
          state_d = RESP;
        end else begin
          psel_d = sel_oh;
          state_d = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: if (PREADY || expired) begin
        psel_d = '0;
        penable_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = (PREADY && !pwrite_q && !PSLVERR) ? PRDATA : '0;
        rsp_err_d = !PREADY || PSLVERR;
        rsp_timeout_d = !PREADY;
        state_d = RESP;
      end
      RESP: if (rsp_valid_q && rsp_ready) begin
        rsp_valid_d = 1'b0;
        rsp_timeout_d = 1'b0;
        state_d = IDLE;
      end else begin
        rsp_valid_d = 1'b1;
      end
    endcase
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q <= IDLE;
      psel_q <= '0;
      penable_q <= 1'b0;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR = paddr_q;
  assign PSEL = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;
  assign PSTRB = pstrb_q;
  assign PPROT = PPROT_DEFAULT;
  assign PNSE = 1'b0;
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed table, reset/backpressure sequence and randomized traffic against a reference model
module tb_apb_requester;
  localparam int TO = 8;
  logic PCLK = 1'b0, PRESETn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0] cmd_strb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
  logic [1:0] PSEL;
  logic PENABLE, PWRITE, PNSE, PREADY, PSLVERR;
  logic [3:0] PSTRB;
  logic [2:0] PPROT;
  int tests = 0, fails = 0;
  int slv_waits = 0, acc_cnt = 0;
  logic slv_hang = 1'b0, slv_err = 1'b0;
  logic [31:0] smem [64];
  logic [5:0] sidx;
  logic [31:0] ref_mem [logic [31:0]];
  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; int waits; logic serr;
    logic [31:0] rdata; logic err; logic to; logic [1:0] psel; int lat; int pcyc;
  } vec_t;
  vec_t tbl [13];
  always #5 PCLK = ~PCLK;
  apb_requester #(.TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PNSE(PNSE), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );
  assign sidx = {PADDR[13:12], PADDR[5:2]};
  assign PREADY = (PSEL != 0) && PENABLE && !slv_hang && (acc_cnt == slv_waits);
  assign PSLVERR = PREADY && slv_err;
  assign PRDATA = smem[sidx];
  always @(posedge PCLK) begin
    acc_cnt <= ((PSEL != 0) && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
    if (PREADY && PWRITE && !slv_err)
      for (int b = 0; b < 4; b++) if (PSTRB[b]) smem[sidx][8*b+:8] <= PWDATA[8*b+:8];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge PCLK) if (PRESETn) begin
    chk("psel_onehot", 32'($countones(PSEL) <= 1), 1);
    chk("penable_without_psel", 32'(!PENABLE || PSEL != 0), 1);
    chk("pprot", 32'(PPROT), 0);
    chk("pnse", 32'(PNSE), 0);
  end
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [31:0] old;
    r.to = 1'b0;
    r.rdata = '0;
    if (v.addr[31:12] >= 2) begin
      r.err = 1'b1; r.psel = 2'b00; r.lat = 2; r.pcyc = 0;
    end else begin
      r.psel = v.addr[31:12] == 0 ? 2'b01 : 2'b10;
      if (v.waits < 0) begin
        r.err = 1'b1; r.to = 1'b1; r.lat = 2 + TO; r.pcyc = 1 + TO;
      end else begin
        r.err = v.serr; r.lat = 3 + v.waits; r.pcyc = 2 + v.waits;
        old = ref_mem.exists(v.addr) ? ref_mem[v.addr] : 32'h0;
        if (!v.wr && !v.serr) r.rdata = old;
        if (v.wr && !v.serr) begin
          for (int b = 0; b < 4; b++) if (v.strb[b]) old[8*b+:8] = v.wdata[8*b+:8];
          ref_mem[v.addr] = old;
        end
      end
    end
    return r;
  endfunction
  task automatic run_txn(input vec_t v, input int rdly);
    int n = 0, cyc = 1, pc = 0;
    while (!cmd_ready && n < 20) begin @(posedge PCLK); #1; n++; end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    slv_waits = v.waits < 0 ? 0 : v.waits;
    slv_hang = v.waits < 0;
    slv_err = v.serr;
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb; cmd_valid = 1'b1;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    while (!rsp_valid && cyc < 40) begin
      if (cyc == 1) begin
        chk("setup_psel", 32'(PSEL), 32'(v.psel));
        chk("setup_penable", 32'(PENABLE), 0);
      end
      if (cyc == 2) chk("access_penable", 32'(PENABLE), 32'(v.psel != 0));
      if (PSEL != 0) begin
        pc++;
        chk("paddr", PADDR, v.addr);
        chk("pwrite", 32'(PWRITE), 32'(v.wr));
        chk("pwdata", PWDATA, v.wr ? v.wdata : 32'h0);
        chk("pstrb", 32'(PSTRB), v.wr ? 32'(v.strb) : 32'h0);
      end
      chk("cmd_ready_busy", 32'(cmd_ready), 0);
      @(posedge PCLK); #1; cyc++;
    end
    chk("latency", cyc, v.lat);
    chk("psel_cycles", pc, v.pcyc);
    chk("rsp_rdata", rsp_rdata, v.rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(v.to));
    chk("psel_in_resp", 32'(PSEL), 0);
    repeat (rdly) begin
      @(posedge PCLK); #1;
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_rdata", rsp_rdata, v.rdata);
      chk("hold_err", 32'(rsp_err), 32'(v.err));
      chk("hold_timeout", 32'(rsp_timeout), 32'(v.to));
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid), 0);
    chk("timeout_cleared", 32'(rsp_timeout), 0);
    chk("cmd_ready_back", 32'(cmd_ready), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    int sel, word;
    for (int i = 0; i < 64; i++) smem[i] = '0;
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0,         1'b0, 1'b0, 2'b01, 3, 2};
    tbl[1]  = '{1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h0,         1'b0, 1'b0, 2'b10, 4, 3};
    tbl[2]  = '{1'b0, 32'h0000_1004, 32'h0,         4'hF, 3, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 2'b10, 6, 5};
    tbl[3]  = '{1'b1, 32'h0000_0008, 32'hAAAA_5555, 4'hF, 0, 1'b0, 32'h0,         1'b0, 1'b0, 2'b01, 3, 2};
    tbl[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 1'b1, 32'h0,         1'b1, 1'b0, 2'b01, 3, 2};
    tbl[5]  = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 0, 1'b0, 32'h0,         1'b1, 1'b0, 2'b00, 2, 0};
    tbl[6]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, -1, 1'b0, 32'h0,        1'b1, 1'b1, 2'b01, 10, 9};
    tbl[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b01, 3, 2};
    tbl[8]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 2, 1'b0, 32'h0,         1'b0, 1'b0, 2'b01, 5, 4};
    tbl[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1, 1'b0, 32'hDE22_BE44, 1'b0, 1'b0, 2'b01, 4, 3};
    tbl[10] = '{1'b1, 32'h0000_1008, 32'hCAFE_F00D, 4'hF, 2, 1'b1, 32'h0,         1'b1, 1'b0, 2'b10, 5, 4};
    tbl[11] = '{1'b0, 32'h0000_1008, 32'h0,         4'h0, 0, 1'b0, 32'h0,         1'b0, 1'b0, 2'b10, 3, 2};
    tbl[12] = '{1'b1, 32'h0000_3004, 32'h5A5A_5A5A, 4'hF, 0, 1'b0, 32'h0,         1'b1, 1'b0, 2'b00, 2, 0};
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel", 32'(PSEL), 0);
    chk("rst_penable", 32'(PENABLE), 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", 32'(PWRITE), 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", 32'(PSTRB), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    PRESETn = 1'b1;
    for (int i = 0; i < 13; i++) begin
      void'(model(tbl[i]));
      run_txn(tbl[i], i % 3);
    end
    while (!cmd_ready) begin @(posedge PCLK); #1; end
    slv_hang = 1'b1; slv_err = 1'b0;
    cmd_write = 1'b0; cmd_addr = 32'h0000_0010; cmd_valid = 1'b1;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge PCLK); #1; end
    chk("pre_rst_psel", 32'(PSEL), 1);
    chk("pre_rst_penable", 32'(PENABLE), 1);
    PRESETn = 1'b0;
    #1;
    chk("midrst_psel", 32'(PSEL), 0);
    chk("midrst_penable", 32'(PENABLE), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    slv_hang = 1'b0;
    repeat (4) begin
      @(posedge PCLK); #1;
      chk("postrst_no_rsp", 32'(rsp_valid), 0);
    end
    v = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 0, 0};
    run_txn(model(v), 5);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      word = $urandom_range(0, 7);
      v.wr = 1'($urandom_range(0, 1));
      v.addr = 32'((sel << 12) | (word << 2));
      v.wdata = $urandom;
      v.strb = 4'($urandom_range(0, 15));
      v.waits = $urandom_range(0, 3);
      v.serr = $urandom_range(0, 7) == 0;
      run_txn(model(v), $urandom_range(0, 2));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
